// File: rtl/adder_share_pkg.sv
// Shared helpers for the adder-sharing arbiter: pipeline depth and requester-tag width.
package adder_share_pkg;

  // Depth of the pipelined reduction adder. The adder registers its padded operand
  // vector once, then adds pairs in a binary tree with one register rank per tree level.
  function automatic int latency_f(input int numbers_amount);
    int n_even;
    n_even = numbers_amount + (numbers_amount % 2);
    return $clog2(n_even) + 1;
  endfunction

  function automatic int tag_width_f(input int req_amount);
    return (req_amount <= 2) ? 1 : $clog2(req_amount);
  endfunction

endpackage

// File: rtl/pipeline_adder.sv
// Pipelined reduction adder: a register rank for the operands, then one rank per tree level.
// A stalled output freezes the whole pipe. Empty output slots never stall it.
module pipeline_adder
  import adder_share_pkg::*;
#(
  parameter int NUMBERS_AMOUNT = 10,
  parameter int NUMBER_WIDTH   = 10,
  parameter int SUM_WIDTH      = NUMBER_WIDTH + $clog2(NUMBERS_AMOUNT),
  parameter bit SIGNED         = 1'b0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUMBERS_AMOUNT*NUMBER_WIDTH-1:0] data_i,
  input  logic                                   data_valid_i,
  output logic                                   ready_o,
  output logic [SUM_WIDTH-1:0]                   data_o,
  output logic                                   data_valid_o,
  input  logic                                   ready_i
);

  localparam int LATENCY = latency_f(NUMBERS_AMOUNT);
  localparam int LEAVES  = 2 ** (LATENCY - 1);

  // Heap-ordered tree: node[1] is the root, node[LEAVES..2*LEAVES-1] hold the operands.
  logic [SUM_WIDTH-1:0]           node [1:2*LEAVES-1];
  logic [LATENCY-1:0]             vld;
  logic [LEAVES*NUMBER_WIDTH-1:0] data_pad;
  logic                           adv;

  function automatic logic [SUM_WIDTH-1:0] ext_f(input logic [NUMBER_WIDTH-1:0] v);
    if (SIGNED) return SUM_WIDTH'($signed(v));
    return SUM_WIDTH'(v);
  endfunction

  assign data_pad = (LEAVES*NUMBER_WIDTH)'(data_i);
  assign adv      = ready_i | ~vld[LATENCY-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld <= '0;
      for (int i = 1; i < 2*LEAVES; i++) node[i] <= '0;
    end else if (adv) begin
      vld <= {vld[LATENCY-2:0], data_valid_i};
      for (int i = 1; i < LEAVES; i++) node[i] <= node[2*i] + node[2*i+1];
      for (int j = 0; j < LEAVES; j++) node[LEAVES+j] <= ext_f(data_pad[j*NUMBER_WIDTH +: NUMBER_WIDTH]);
    end
  end

  assign ready_o      = adv;
  assign data_o       = node[1];
  assign data_valid_o = vld[LATENCY-1];

endmodule

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter: the search starts at ptr and wraps around.
// ptr moves one past the winner only when the grant is actually taken.
module rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     req,
  input  logic                 accept,
  output logic [WIDTH-1:0]     grant,
  output logic [IDX_WIDTH-1:0] grant_idx
);

  logic [IDX_WIDTH-1:0] ptr;
  logic                 found;
  int                   k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int off = 0; off < WIDTH; off++) begin
      k = (int'(ptr) + off) % WIDTH;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_WIDTH'(k);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == IDX_WIDTH'(WIDTH - 1)) ? '0 : grant_idx + IDX_WIDTH'(1);
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one pipeline_adder among REQ_AMOUNT requesters. A requester-ID tag rides alongside
// the adder pipe so that each sum is steered back to the requester that issued it.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int REQ_AMOUNT     = 4,
  parameter int NUMBERS_AMOUNT = 10,
  parameter int NUMBER_WIDTH   = 10,
  parameter int SUM_WIDTH      = NUMBER_WIDTH + $clog2(NUMBERS_AMOUNT),
  parameter bit SIGNED         = 1'b0,
  localparam int TAG_WIDTH      = tag_width_f(REQ_AMOUNT),
  localparam int LATENCY        = latency_f(NUMBERS_AMOUNT),
  localparam int INFLIGHT_WIDTH = $clog2(LATENCY + 1)
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [REQ_AMOUNT*NUMBERS_AMOUNT*NUMBER_WIDTH-1:0] req_data_i,
  input  logic [REQ_AMOUNT-1:0]                             req_valid_i,
  output logic [REQ_AMOUNT-1:0]                             req_ready_o,
  output logic [SUM_WIDTH-1:0]                              res_data_o,
  output logic [REQ_AMOUNT-1:0]                             res_valid_o,
  input  logic [REQ_AMOUNT-1:0]                             res_ready_i,
  output logic                                              busy_o,
  output logic [INFLIGHT_WIDTH-1:0]                         inflight_o
);

  localparam int VEC_WIDTH = NUMBERS_AMOUNT * NUMBER_WIDTH;

  logic [REQ_AMOUNT-1:0]     grant;
  logic [TAG_WIDTH-1:0]      grant_idx;
  logic [TAG_WIDTH-1:0]      out_tag;
  logic [TAG_WIDTH-1:0]      tag_pipe [0:LATENCY-1];
  logic [VEC_WIDTH-1:0]      adder_data;
  logic                      adder_ready;
  logic                      adder_valid;
  logic                      adder_out_ready;
  logic                      accept;
  logic                      res_accept;
  logic [INFLIGHT_WIDTH-1:0] inflight;

  rr_arbiter #(
    .WIDTH    (REQ_AMOUNT),
    .IDX_WIDTH(TAG_WIDTH)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req      (req_valid_i),
    .accept   (accept),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign req_ready_o = grant & {REQ_AMOUNT{adder_ready}};
  assign accept      = |(req_valid_i & req_ready_o);
  assign adder_data  = req_data_i[grant_idx*VEC_WIDTH +: VEC_WIDTH];

  pipeline_adder #(
    .NUMBERS_AMOUNT(NUMBERS_AMOUNT),
    .NUMBER_WIDTH  (NUMBER_WIDTH),
    .SUM_WIDTH     (SUM_WIDTH),
    .SIGNED        (SIGNED)
  ) u_adder (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_i      (adder_data),
    .data_valid_i(|req_valid_i),
    .ready_o     (adder_ready),
    .data_o      (res_data_o),
    .data_valid_o(adder_valid),
    .ready_i     (adder_out_ready)
  );

  // Shifts on exactly the same condition as the adder's valid chain, so tags stay aligned
  // with the sums. An idle stage carries a stale tag, which is harmless without a valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
    end else if (adder_ready) begin
      tag_pipe[0] <= grant_idx;
      for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign out_tag         = tag_pipe[LATENCY-1];
  assign adder_out_ready = res_ready_i[out_tag];
  assign res_accept      = adder_valid & adder_out_ready;

  always_comb begin
    res_valid_o = '0;
    if (adder_valid) res_valid_o[out_tag] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight <= '0;
    end else begin
      case ({accept, res_accept})
        2'b10:   inflight <= inflight + INFLIGHT_WIDTH'(1);
        2'b01:   inflight <= inflight - INFLIGHT_WIDTH'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign inflight_o = inflight;
  assign busy_o     = (inflight != '0);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: an unsigned instance for arbitration, latency,
// backpressure and reset, plus a SIGNED=1 instance for sign extension.
module tb_adder_share_arbiter;
  import adder_share_pkg::*;

  localparam int RA  = 4;
  localparam int NA  = 10;
  localparam int NW  = 10;
  localparam int SW  = 14;
  localparam int VW  = NA * NW;
  localparam int LAT = latency_f(NA);
  localparam int IW  = $clog2(LAT + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [RA*VW-1:0] req_data;
  logic [RA-1:0]    req_valid, req_ready, res_valid, res_ready;
  logic [SW-1:0]    res_data;
  logic             busy;
  logic [IW-1:0]    inflight;

  logic [RA*VW-1:0] s_req_data;
  logic [RA-1:0]    s_req_valid, s_req_ready, s_res_valid, s_res_ready;
  logic [SW-1:0]    s_res_data;
  logic             s_busy;
  logic [IW-1:0]    s_inflight;

  int n_checks = 0;
  int n_errors = 0;

  adder_share_arbiter #(
    .REQ_AMOUNT(RA), .NUMBERS_AMOUNT(NA), .NUMBER_WIDTH(NW), .SUM_WIDTH(SW), .SIGNED(1'b0)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .res_data_o(res_data), .res_valid_o(res_valid),
    .res_ready_i(res_ready), .busy_o(busy), .inflight_o(inflight)
  );

  adder_share_arbiter #(
    .REQ_AMOUNT(RA), .NUMBERS_AMOUNT(NA), .NUMBER_WIDTH(NW), .SUM_WIDTH(SW), .SIGNED(1'b1)
  ) u_sdut (
    .clk_i(clk), .rst_i(rst), .req_data_i(s_req_data), .req_valid_i(s_req_valid),
    .req_ready_o(s_req_ready), .res_data_o(s_res_data), .res_valid_o(s_res_valid),
    .res_ready_i(s_res_ready), .busy_o(s_busy), .inflight_o(s_inflight)
  );

  function automatic logic [VW-1:0] fill(input logic [NW-1:0] v);
    logic [VW-1:0] r;
    for (int j = 0; j < NA; j++) r[j*NW +: NW] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] mix(input logic [NW-1:0] lo, input logic [NW-1:0] hi);
    logic [VW-1:0] r;
    for (int j = 0; j < NA; j++) r[j*NW +: NW] = (j < NA/2) ? lo : hi;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    req_data    = '0;
    req_valid   = '0;
    res_ready   = '1;
    s_req_data  = '0;
    s_req_valid = '0;
    s_res_ready = '1;

    // Reset state
    #2;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_busy", 32'(busy), 0);
    req_valid = 4'b1111;
    #1;
    check("rst_grant_prio", 32'(req_ready), 'h1);
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();

    // Single request: ten operands of 1, result 5 cycles after the accepting cycle
    req_data[0*VW +: VW] = fill(10'd1);
    req_valid = 4'b0001;
    #1;
    check("single_ready", 32'(req_ready), 'h1);
    tick();
    req_valid = '0;
    check("single_inflight1", 32'(inflight), 1);
    check("single_busy1", 32'(busy), 1);
    repeat (3) tick();
    check("single_early", 32'(res_valid), 0);
    tick();
    check("single_res_valid", 32'(res_valid), 'h1);
    check("single_res_data", 32'(res_data), 10);
    tick();
    check("single_res_gone", 32'(res_valid), 0);
    check("single_inflight0", 32'(inflight), 0);
    check("single_busy0", 32'(busy), 0);

    // Pointer after gaps (ptr is 1 here): req3 alone, then req0+req2 wraps to req0 first
    req_data[3*VW +: VW] = fill(10'd4);
    req_data[0*VW +: VW] = fill(10'd1);
    req_data[2*VW +: VW] = fill(10'd3);
    req_valid = 4'b1000;
    #1;
    check("ptr_grant3", 32'(req_ready), 'h8);
    tick();
    req_valid = 4'b0101;
    #1;
    check("ptr_grant0", 32'(req_ready), 'h1);
    tick();
    req_valid = 4'b0100;
    #1;
    check("ptr_grant2", 32'(req_ready), 'h4);
    tick();
    req_valid = '0;
    repeat (2) tick();
    check("ptr_res3_valid", 32'(res_valid), 'h8);
    check("ptr_res3_data", 32'(res_data), 40);
    tick();
    check("ptr_res0_valid", 32'(res_valid), 'h1);
    check("ptr_res0_data", 32'(res_data), 10);
    tick();
    check("ptr_res2_valid", 32'(res_valid), 'h4);
    check("ptr_res2_data", 32'(res_data), 30);
    tick();
    check("ptr_drained", 32'(inflight), 0);

    // Reset pulse so round-robin starts at requester 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < RA; k++) req_data[k*VW +: VW] = fill(NW'(k + 1));
    req_valid = 4'b1111;
    #1;

    // Round robin with all requesters valid; stall req2's result at the output at i == 15
    for (int i = 0; i < 23; i++) begin
      if (i == 15) begin
        res_ready = 4'b1011;
        #1;
        check("bp_ready_drop", 32'(req_ready), 0);
        repeat (7) begin
          tick();
          check("bp_req_ready", 32'(req_ready), 0);
          check("bp_res_valid", 32'(res_valid), 'h4);
          check("bp_res_data", 32'(res_data), 30);
          check("bp_inflight", 32'(inflight), 5);
        end
        res_ready = 4'b1111;
        #1;
      end
      check("rr_req_ready", 32'(req_ready), 1 << (i % 4));
      if (i >= 5) begin
        check("rr_res_valid", 32'(res_valid), 1 << ((i - 5) % 4));
        check("rr_res_data", 32'(res_data), 10 * ((i - 5) % 4 + 1));
      end else begin
        check("rr_res_idle", 32'(res_valid), 0);
      end
      check("rr_inflight", 32'(inflight), (i < 5) ? i : 5);
      tick();
    end
    req_valid = '0;
    repeat (5) tick();
    check("rr_drain_inflight", 32'(inflight), 0);
    check("rr_drain_busy", 32'(busy), 0);
    check("rr_drain_valid", 32'(res_valid), 0);

    // Reset with three vectors in flight
    req_valid = 4'b1111;
    repeat (3) tick();
    req_valid = '0;
    #1;
    check("mid_inflight3", 32'(inflight), 3);
    rst = 1'b1;
    #1;
    check("mid_rst_inflight", 32'(inflight), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(res_valid), 0);
    tick();
    rst = 1'b0;
    repeat (6) begin
      tick();
      check("mid_no_result", 32'(res_valid), 0);
    end
    req_valid = 4'b1111;
    #1;
    check("mid_next_grant", 32'(req_ready), 'h1);
    req_valid = '0;

    // Signed instance: all -1 gives -10, five -1 plus five 3 gives 10
    s_req_data[0*VW +: VW] = fill(10'h3FF);
    s_req_valid = 4'b0001;
    #1;
    check("s_ready", 32'(s_req_ready), 'h1);
    tick();
    s_req_data[0*VW +: VW] = mix(10'h3FF, 10'd3);
    tick();
    s_req_valid = '0;
    repeat (3) tick();
    check("s_neg_valid", 32'(s_res_valid), 'h1);
    check("s_neg_data", 32'(s_res_data), 'h3FF6);
    tick();
    check("s_mix_valid", 32'(s_res_valid), 'h1);
    check("s_mix_data", 32'(s_res_data), 10);
    tick();
    check("s_inflight0", 32'(s_inflight), 0);
    check("s_busy0", 32'(s_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
